// File: rtl/aes256_dec_key_sched_pkg.sv
// Shared widths, types and GF(2^8) / key-schedule helpers for the AES-256 decryption key scheduler.
package aes256_dec_key_sched_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned BLK_W     = 256;
    localparam int unsigned RK_W      = 128;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = 3;
    localparam int unsigned AES256_NR = 14;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BLK_W-1:0]  block_t;
    typedef logic [RK_W-1:0]   rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (bits 1..7 of the exponent set), then the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [CNT_W-1:0] k);
        logic [7:0] rc;
        case (k)
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // Word i of a block; word 0 sits in the top 32 bits
    function automatic word_t get_word(input block_t b, input int i);
        return b[BLK_W-1-WORD_W*i -: WORD_W];
    endfunction

    function automatic block_t fwd_step(input block_t w, input logic [7:0] rc);
        word_t n0, n1, n2, n3, n4, n5, n6, n7;
        n0 = get_word(w, 0) ^ sub_word(rot_word(get_word(w, 7))) ^ {rc, 24'h000000};
        n1 = get_word(w, 1) ^ n0;
        n2 = get_word(w, 2) ^ n1;
        n3 = get_word(w, 3) ^ n2;
        n4 = get_word(w, 4) ^ sub_word(n3);
        n5 = get_word(w, 5) ^ n4;
        n6 = get_word(w, 6) ^ n5;
        n7 = get_word(w, 7) ^ n6;
        return {n0, n1, n2, n3, n4, n5, n6, n7};
    endfunction

    function automatic rkey_t inv_mix_columns(input rkey_t s);
        rkey_t      r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[RK_W-1-WORD_W*c -: WORD_W];
            r[RK_W-1-WORD_W*c -: WORD_W] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes256_key_step_inv.sv
// Combinational inverse AES-256 schedule step: recovers block k-1 from block k.
module aes256_key_step_inv
    import aes256_dec_key_sched_pkg::*;
(
    input  logic [BLK_W-1:0] blk_i,
    input  logic [7:0]       rc_i,
    output logic [BLK_W-1:0] prev_blk_o
);

    word_t n [8];
    word_t w [8];

    // Upper half unwinds first: w0 needs the recovered w7
    always_comb begin
        for (int i = 0; i < 8; i++) n[i] = get_word(blk_i, i);
        w[7] = n[7] ^ n[6];
        w[6] = n[6] ^ n[5];
        w[5] = n[5] ^ n[4];
        w[4] = n[4] ^ sub_word(n[3]);
        w[3] = n[3] ^ n[2];
        w[2] = n[2] ^ n[1];
        w[1] = n[1] ^ n[0];
        w[0] = n[0] ^ sub_word(rot_word(w[7])) ^ {rc_i, 24'h000000};
    end

    assign prev_blk_o = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};

endmodule

// File: rtl/aes256_dec_key_sched.sv
// AES-256 decryption round-key generator: expands forward to block 7, then streams rk14..rk0
// by walking the schedule backwards, holding a single 256-bit block.
module aes256_dec_key_sched
    import aes256_dec_key_sched_pkg::*;
#(
    parameter bit EQUIV_DECRYPT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [BLK_W-1:0] key_i,
    input  logic             abort_i,
    output logic             rk_valid_o,
    input  logic             rk_ready_i,
    output logic [RK_W-1:0]  rk_o,
    output logic [IDX_W-1:0] rk_idx_o,
    output logic             rk_last_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    block_t           blk_q, blk_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    block_t           prev_blk;
    logic [7:0]       rc_inv;
    rkey_t            raw_rk;

    // Block k was produced from block k-1 with rcon(k), and rk 2k lives in block k
    assign rc_inv = rcon(idx_q[IDX_W-1:1]);

    aes256_key_step_inv u_step_inv (
        .blk_i      (blk_q),
        .rc_i       (rc_inv),
        .prev_blk_o (prev_blk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid_i) begin
                    blk_d   = key_i;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                blk_d = fwd_step(blk_q, rcon(cnt_q));
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) begin
                    state_d = ST_OUT;
                    idx_d   = IDX_W'(AES256_NR);
                    vld_d   = 1'b1;
                end
            end
            ST_OUT: begin
                if (rk_ready_i) begin
                    if (idx_q == '0) begin
                        state_d = ST_IDLE;
                        vld_d   = 1'b0;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                        // Leaving an even (hi) key means the whole block is spent
                        if (!idx_q[0]) blk_d = prev_blk;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
            blk_d   = '0;
            cnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
        end
    end

    assign raw_rk = idx_q[0] ? blk_q[RK_W-1:0] : blk_q[BLK_W-1:RK_W];

    always_comb begin
        rk_o = raw_rk;
        if (EQUIV_DECRYPT && (idx_q != '0) && (idx_q != IDX_W'(AES256_NR))) begin
            rk_o = inv_mix_columns(raw_rk);
        end
    end

    assign key_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rk_valid_o  = vld_q;
    assign rk_idx_o    = idx_q;
    assign rk_last_o   = vld_q && (idx_q == '0);

endmodule

// File: tb/tb_aes256_dec_key_sched.sv
// Bench for aes256_dec_key_sched: raw and equivalent-inverse instances against a FIPS-style key expansion model.
module tb_aes256_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [255:0] key;
    logic         abort;
    logic         rk_ready;

    logic         key_ready, rk_valid, rk_last, busy;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         key_ready_e, rk_valid_e, rk_last_e, busy_e;
    logic [127:0] rk_e;
    logic [3:0]   rk_idx_e;

    logic [7:0]   sb [256];
    logic [31:0]  w [60];
    logic [127:0] exp_rk [15];
    logic [127:0] exp_eq [15];
    logic [127:0] got_rk [15];

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] A3_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    aes256_dec_key_sched #(.EQUIV_DECRYPT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid), .key_ready_o(key_ready), .key_i(key),
        .abort_i(abort), .rk_valid_o(rk_valid), .rk_ready_i(rk_ready), .rk_o(rk),
        .rk_idx_o(rk_idx), .rk_last_o(rk_last), .busy_o(busy));

    aes256_dec_key_sched #(.EQUIV_DECRYPT(1'b1)) u_dut_eq (
        .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid), .key_ready_o(key_ready_e), .key_i(key),
        .abort_i(abort), .rk_valid_o(rk_valid_e), .rk_ready_i(rk_ready), .rk_o(rk_e),
        .rk_idx_o(rk_idx_e), .rk_last_o(rk_last_e), .busy_o(busy_e));

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011b << (i - 8));
        return acc[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = b;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Matrix product with circulant rows {0e,0b,0d,09}
    function automatic logic [127:0] imc(input logic [127:0] s);
        logic [127:0] r;
        logic [31:0]  cf;
        logic [7:0]   acc;
        cf = 32'h0e0b0d09;
        r  = '0;
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(cf[31-8*((k-row+4)%4) -: 8], s[127-32*col-8*k -: 8]);
                r[127-32*col-8*row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 15; j++) begin
            exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
            exp_eq[j] = (j == 0 || j == 14) ? exp_rk[j] : imc(exp_rk[j]);
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " key_ready"}, 256'(key_ready), 256'(1));
        chk({nm, " rk_valid"}, 256'(rk_valid), 256'(0));
        chk({nm, " busy"}, 256'(busy), 256'(0));
        chk({nm, " rk"}, 256'(rk), 256'(0));
        chk({nm, " rk_idx"}, 256'(rk_idx), 256'(0));
        chk({nm, " rk_last"}, 256'(rk_last), 256'(0));
        chk({nm, " eq state"}, 256'({key_ready_e, rk_valid_e, busy_e, rk_last_e}), 256'(4'b1000));
        chk({nm, " eq rk"}, 256'({rk_e, rk_idx_e}), 256'(0));
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_stream(input string nm, input logic [255:0] k, input bit rnd,
                              input int abort_at, input bit hold_kv);
        int           cyc;
        int           exp_idx;
        bit           acc;
        bit           stalled;
        bit           done;
        logic [127:0] prev;
        expand(k);
        @(negedge clk);
        chk({nm, " ready before key"}, 256'(key_ready), 256'(1));
        key_valid = 1'b1;
        key       = k;
        rk_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (hold_kv) key = ~k;
        else key_valid = 1'b0;
        chk({nm, " busy after accept"}, 256'({busy, key_ready}), 256'(2'b10));
        cyc = 0;
        while (!rk_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
        end
        chk({nm, " rk14 latency"}, 256'(cyc), 256'(7));
        exp_idx = 14;
        stalled = 1'b0;
        done    = 1'b0;
        prev    = '0;
        for (int n = 0; n < 200 && !done; n++) begin
            chk({nm, " rk_valid"}, 256'(rk_valid), 256'(1));
            chk({nm, " rk_idx"}, 256'(rk_idx), 256'(exp_idx));
            chk({nm, " rk"}, 256'(rk), 256'(exp_rk[exp_idx]));
            chk({nm, " rk equiv"}, 256'({rk_e, rk_idx_e}), 256'({exp_eq[exp_idx], 4'(exp_idx)}));
            chk({nm, " rk_last"}, 256'(rk_last), 256'(exp_idx == 0));
            chk({nm, " key_ready busy"}, 256'(key_ready), 256'(0));
            if (stalled) chk({nm, " stall hold"}, 256'(rk), 256'(prev));
            got_rk[exp_idx] = rk;
            prev            = rk;
            if (exp_idx == abort_at) begin
                abort     = 1'b1;
                key_valid = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                chk({nm, " abort idle"}, 256'({rk_valid, key_ready, busy}), 256'(3'b010));
                done = 1'b1;
            end else begin
                acc      = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                rk_ready = acc;
                if (acc && exp_idx == 0) key_valid = 1'b0;
                @(negedge clk);
                stalled = !acc;
                if (acc) begin
                    if (exp_idx == 0) begin
                        chk({nm, " end idle"}, 256'({rk_valid, key_ready, busy}), 256'(3'b010));
                        done = 1'b1;
                    end else begin
                        exp_idx--;
                    end
                end
            end
        end
        chk({nm, " stream completed"}, 256'(done), 256'(1));
        rk_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        abort     = 1'b0;
        rk_ready  = 1'b0;
        build_sbox();
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        run_stream("c3", C3_KEY, 1'b0, -1, 1'b0);
        chk("c3 rk14 vector", 256'(got_rk[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        chk("c3 rk1 vector", 256'(got_rk[1]), 256'(128'h101112131415161718191a1b1c1d1e1f));
        chk("c3 rk0 vector", 256'(got_rk[0]), 256'(128'h000102030405060708090a0b0c0d0e0f));

        run_stream("a3", A3_KEY, 1'b1, -1, 1'b1);
        chk("a3 rk14 vector", 256'(got_rk[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));

        for (int r = 0; r < 3; r++) run_stream("rand", rand_key(), 1'b1, -1, r[0]);

        run_stream("abort", rand_key(), 1'b1, 9, 1'b0);
        run_stream("post abort", C3_KEY, 1'b0, -1, 1'b0);

        @(negedge clk);
        abort     = 1'b1;
        key_valid = 1'b1;
        key       = rand_key();
        @(negedge clk);
        chk("abort beats key", 256'({busy, key_ready}), 256'(2'b01));
        abort     = 1'b0;
        key_valid = 1'b0;

        @(negedge clk);
        key_valid = 1'b1;
        key       = A3_KEY;
        @(negedge clk);
        key = rand_key();
        repeat (3) @(negedge clk);
        chk("held key ignored", 256'({busy, key_ready, rk_valid}), 256'(3'b100));
        rst_n = 1'b0;
        #1;
        chk_reset("mid fwd reset");
        key_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream("post reset", rand_key(), 1'b1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
